mips_state_dumper: RTL and testbench

- Synthesizable run-control and state-dump block for the MIPS core.
- Gates the CPU clock-enable for a bounded run. The run stops on a cycle limit or a PC breakpoint.
- After the stop, streams PC, every register-file entry and a window of data-memory words over a valid/ready interface.
- Replaces fixed-delay bench dumps with a parametrised, handshaked, hardware-observable mechanism usable in simulation and on FPGA.

---
 rtl/mips_dbg_pkg.sv | 21 ++
 rtl/dump_out_stage.sv | 39 +++
 rtl/mips_state_dumper.sv | 169 ++++++++++++++++
 tb/tb_mips_state_dumper.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS run-control / state-dump block.
// Holds the FSM state encoding, dump beat kinds and halt_reason bit positions.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DUMP_PC,
        DUMP_REG,
        DUMP_MEM,
        DONE
    } state_t;

    localparam logic [1:0] KIND_PC  = 2'd0;
    localparam logic [1:0] KIND_REG = 2'd1;
    localparam logic [1:0] KIND_MEM = 2'd2;

    localparam int HALT_LIM_BIT = 0;
    localparam int HALT_PC_BIT  = 1;

endpackage

// File: rtl/dump_out_stage.sv
// Single-entry valid/ready holding register for dump beats {kind, index, data}.
// Contents stay stable while valid is high and ready is low.
module dump_out_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [1:0]        load_kind,
    input  logic [7:0]        load_index,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [1:0]        kind,
    output logic [7:0]        index,
    output logic [DATA_W-1:0] data,
    output logic              can_load
);

    // Space is available when empty or when the held beat leaves this cycle.
    assign can_load = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            kind  <= '0;
            index <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            kind  <= load_kind;
            index <= load_index;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_state_dumper.sv
// Run-control and state-dump block: gates the CPU for a bounded run, then
// streams PC, register file and a data-memory window over valid/ready.
module mips_state_dumper
    import mips_dbg_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          REG_COUNT = 32,
    parameter int          REG_AW    = 5,
    parameter logic [31:0] MEM_BASE  = 32'h0,
    parameter int          MEM_WORDS = 12,
    parameter int          CYCLE_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CYCLE_W-1:0] cycle_limit,
    input  logic               halt_pc_en,
    input  logic [DATA_W-1:0]  halt_pc,
    input  logic [DATA_W-1:0]  cpu_pc,
    output logic               cpu_run,
    output logic [REG_AW-1:0]  rf_raddr,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic [31:0]        dm_raddr,
    input  logic [DATA_W-1:0]  dm_rdata,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [1:0]         dump_kind,
    output logic [7:0]         dump_index,
    output logic [DATA_W-1:0]  dump_data,
    output logic [CYCLE_W-1:0] cycles_run,
    output logic [1:0]         halt_reason,
    output logic               busy,
    output logic               done
);

    localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);
    localparam logic [7:0] MEM_END  = 8'(MEM_WORDS);

    state_t              state, state_n;
    logic [7:0]          idx, idx_n;
    logic [CYCLE_W-1:0]  limit_q;
    logic                pc_en_q;
    logic [DATA_W-1:0]   halt_pc_q;
    logic                start_ok, start_pcm, lim, pcm, stop;
    logic                can_load, load;
    logic [1:0]          load_kind;
    logic [DATA_W-1:0]   load_data;

    assign start_ok  = start && (state == IDLE || state == DONE);
    assign start_pcm = halt_pc_en && (cpu_pc == halt_pc);
    assign lim       = (cycles_run == limit_q);
    assign pcm       = pc_en_q && (cpu_pc == halt_pc_q);
    assign stop      = (state == RUN) && (lim || pcm);

    assign cpu_run = (state == RUN) && !stop;
    assign busy    = (state == RUN) || (state == DUMP_PC) ||
                     (state == DUMP_REG) || (state == DUMP_MEM);
    assign done    = (state == DONE);

    assign rf_raddr = (state == DUMP_REG) ? REG_AW'(idx) : '0;
    // Only drive an address while a window word is still to be fetched.
    assign dm_raddr = (state == DUMP_MEM && idx < MEM_END) ?
                      MEM_BASE + {22'd0, idx, 2'b00} : 32'd0;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        load      = 1'b0;
        load_kind = KIND_PC;
        load_data = '0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    // A zero limit runs no CPU cycles, so skip RUN entirely.
                    state_n = (cycle_limit == '0) ? DUMP_PC : RUN;
                    idx_n   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = DUMP_PC;
                    idx_n   = '0;
                end
            end
            DUMP_PC: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_kind = KIND_PC;
                    load_data = cpu_pc;
                    state_n   = DUMP_REG;
                    idx_n     = '0;
                end
            end
            DUMP_REG: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_kind = KIND_REG;
                    load_data = rf_rdata;
                    if (idx == REG_LAST) begin
                        state_n = DUMP_MEM;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end
            end
            DUMP_MEM: begin
                // Once all words are loaded, wait for the final beat to leave.
                if (idx == MEM_END) begin
                    if (can_load) state_n = DONE;
                end else if (can_load) begin
                    load      = 1'b1;
                    load_kind = KIND_MEM;
                    load_data = dm_rdata;
                    idx_n     = idx + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q     <= '0;
            pc_en_q     <= 1'b0;
            halt_pc_q   <= '0;
            cycles_run  <= '0;
            halt_reason <= '0;
        end else if (start_ok) begin
            limit_q     <= cycle_limit;
            pc_en_q     <= halt_pc_en;
            halt_pc_q   <= halt_pc;
            cycles_run  <= '0;
            halt_reason <= (cycle_limit == '0) ? {start_pcm, 1'b1} : 2'b00;
        end else begin
            if (cpu_run && cycles_run != '1) cycles_run <= cycles_run + CYCLE_W'(1);
            if (stop) begin
                halt_reason[HALT_LIM_BIT] <= lim;
                halt_reason[HALT_PC_BIT]  <= pcm;
            end
        end
    end

    dump_out_stage #(.DATA_W(DATA_W)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_kind  (load_kind),
        .load_index (idx),
        .load_data  (load_data),
        .ready      (dump_ready),
        .valid      (dump_valid),
        .kind       (dump_kind),
        .index      (dump_index),
        .data       (dump_data),
        .can_load   (can_load)
    );

endmodule

// File: tb/tb_mips_state_dumper.sv
// Self-checking bench for mips_state_dumper: randomized runs against a
// behavioural run/dump model, plus a second instance with a small memory window.
module tb_mips_state_dumper;
    import mips_dbg_pkg::*;

    localparam int REG_COUNT = 32;
    localparam int MEM_WORDS = 12;
    localparam int BEATS     = 1 + REG_COUNT + MEM_WORDS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, halt_pc_en, cpu_run, dump_valid, dump_ready, busy, done;
    logic [31:0] cycle_limit, halt_pc, cpu_pc, rf_rdata, dm_raddr, dm_rdata, dump_data, cycles_run;
    logic [4:0]  rf_raddr;
    logic [1:0]  dump_kind, halt_reason;
    logic [7:0]  dump_index;

    logic        start2, cpu_run2, dump_valid2, dump_ready2, busy2, done2, halt_pc_en2;
    logic [31:0] cycle_limit2, halt_pc2, cpu_pc2, rf_rdata2, dm_raddr2, dm_rdata2, dump_data2, cycles_run2;
    logic [4:0]  rf_raddr2;
    logic [1:0]  dump_kind2, halt_reason2;
    logic [7:0]  dump_index2;

    logic [31:0] rf  [32];
    logic [31:0] mem [64];
    assign rf_rdata  = rf[rf_raddr];
    assign dm_rdata  = mem[dm_raddr[7:2]];
    assign rf_rdata2 = rf[rf_raddr2];
    assign dm_rdata2 = mem[dm_raddr2[7:2]];

    mips_state_dumper dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cycle_limit(cycle_limit),
        .halt_pc_en(halt_pc_en), .halt_pc(halt_pc), .cpu_pc(cpu_pc), .cpu_run(cpu_run),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_kind(dump_kind),
        .dump_index(dump_index), .dump_data(dump_data), .cycles_run(cycles_run),
        .halt_reason(halt_reason), .busy(busy), .done(done)
    );

    mips_state_dumper #(.MEM_BASE(32'h20), .MEM_WORDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cycle_limit(cycle_limit2),
        .halt_pc_en(halt_pc_en2), .halt_pc(halt_pc2), .cpu_pc(cpu_pc2), .cpu_run(cpu_run2),
        .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .dm_raddr(dm_raddr2), .dm_rdata(dm_rdata2),
        .dump_valid(dump_valid2), .dump_ready(dump_ready2), .dump_kind(dump_kind2),
        .dump_index(dump_index2), .dump_data(dump_data2), .cycles_run(cycles_run2),
        .halt_reason(halt_reason2), .busy(busy2), .done(done2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // CPU model: PC advances by 4 on every enabled cycle.
    logic pc_clear = 1'b1;
    always @(posedge clk) begin
        if (pc_clear) cpu_pc <= 32'd0;
        else if (cpu_run) cpu_pc <= cpu_pc + 32'd4;
    end

    int ready_mode = 0;
    int pat_cnt    = 0;
    logic [3:0] ready_pat = 4'b1001;
    initial begin
        dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dump_ready = 1'b1;
                1: begin dump_ready = ready_pat[pat_cnt % 4]; pat_cnt++; end
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic [41:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [41:0] prev_beat = '0;
    int          run_cnt = 0;
    int          valid_cnt = 0;

    always @(negedge clk) begin
        logic [41:0] e;
        if (cpu_run) run_cnt++;
        if (dump_valid) valid_cnt++;
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_kind",  dump_kind,  prev_beat[41:40]);
                check("hold_index", dump_index, prev_beat[39:32]);
                check("hold_data",  dump_data,  prev_beat[31:0]);
            end
            if (dump_valid && dump_ready) begin
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_kind",  dump_kind,  e[41:40]);
                    check("beat_index", dump_index, e[39:32]);
                    check("beat_data",  dump_data,  e[31:0]);
                end
            end
        end
        prev_stall = mon_en && dump_valid && !dump_ready;
        prev_beat  = {dump_kind, dump_index, dump_data};
    end

    logic [39:0] mem2_q[$];
    logic [31:0] addr2_q[$];
    int          run_cnt2 = 0;
    int          beat_cnt2 = 0;
    always @(negedge clk) begin
        if (cpu_run2) run_cnt2++;
        if (dump_valid2 && dump_ready2) begin
            beat_cnt2++;
            if (dump_kind2 == KIND_MEM) mem2_q.push_back({dump_index2, dump_data2});
        end
        if (dm_raddr2 != 32'd0) addr2_q.push_back(dm_raddr2);
    end

    task automatic clear_pc();
        @(negedge clk) pc_clear = 1'b1;
        @(negedge clk) pc_clear = 1'b0;
    endtask

    task automatic fill_state();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
    endtask

    // Reference: walk the CPU forward one PC step at a time until a stop rule fires.
    task automatic do_run(input logic [31:0] limit, input logic en, input logic [31:0] hpc,
                          input int mode);
        logic [31:0] pc0;
        int          n, waited;
        logic        lim_hit, pc_hit;
        pc0 = cpu_pc;
        n = 0; lim_hit = 1'b0; pc_hit = 1'b0;
        for (int k = 0; k <= int'(limit); k++) begin
            n = k;
            lim_hit = (k == int'(limit));
            pc_hit  = en && (pc0 + 32'(4 * k) == hpc);
            if (lim_hit || pc_hit) break;
        end
        exp_q.delete();
        exp_q.push_back({KIND_PC, 8'd0, pc0 + 32'(4 * n)});
        for (int i = 0; i < REG_COUNT; i++) exp_q.push_back({KIND_REG, 8'(i), rf[i]});
        for (int i = 0; i < MEM_WORDS; i++) exp_q.push_back({KIND_MEM, 8'(i), mem[i]});
        ready_mode = mode;
        @(negedge clk);
        mon_en = 1'b1; run_cnt = 0; valid_cnt = 0;
        start = 1'b1; cycle_limit = limit; halt_pc_en = en; halt_pc = hpc;
        @(negedge clk);
        start = 1'b0; cycle_limit = $urandom; halt_pc_en = 1'($urandom_range(0, 1)); halt_pc = $urandom;
        waited = 0;
        while (!done && waited < 4000) begin @(negedge clk); waited++; end
        check("run_done", done, 1'b1);
        check("run_cycles_seen", run_cnt, n);
        check("run_cycles_run", cycles_run, n);
        check("run_halt_reason", halt_reason, {pc_hit, lim_hit});
        check("run_beats_left", exp_q.size(), 0);
        check("run_busy_low", busy, 1'b0);
        check("run_final_pc", cpu_pc, pc0 + 32'(4 * n));
        if (mode == 0) check("run_beat_cycles", valid_cnt, BEATS);
        mon_en = 1'b0;
    endtask

    initial begin
        int waited;
        logic [31:0] pc0;
        rst_n = 1'b0; start = 1'b0; cycle_limit = '0; halt_pc_en = 1'b0; halt_pc = '0;
        start2 = 1'b0; cycle_limit2 = '0; halt_pc_en2 = 1'b0; halt_pc2 = '0; cpu_pc2 = '0;
        dump_ready2 = 1'b1;
        fill_state();
        repeat (3) @(negedge clk);
        check("rst_cpu_run", cpu_run, 1'b0);
        check("rst_valid", dump_valid, 1'b0);
        check("rst_beat", {dump_kind, dump_index, dump_data}, 42'd0);
        check("rst_cycles", cycles_run, 32'd0);
        check("rst_reason", halt_reason, 2'd0);
        check("rst_busy_done", {busy, done}, 2'd0);
        check("rst_addrs", {rf_raddr, dm_raddr}, 37'd0);
        rst_n = 1'b1;
        pc_clear = 1'b0;

        do_run(32'd5, 1'b0, 32'd0, 0);
        clear_pc();
        do_run(32'd100, 1'b1, 32'h0000_000C, 0);
        clear_pc();
        do_run(32'd3, 1'b1, 32'h0000_000C, 2);
        clear_pc();
        fill_state();
        rf[8] = 32'h0000_7E57;
        do_run(32'd7, 1'b0, 32'd0, 1);
        // Rerun from DONE continues from the current CPU PC.
        pc0 = cpu_pc;
        do_run(32'($urandom_range(1, 20)), 1'b1, pc0 + 32'(4 * $urandom_range(0, 25)), 2);

        // Asynchronous reset in the middle of the register dump.
        ready_mode = 0;
        @(negedge clk) start = 1'b1; cycle_limit = 32'd2; halt_pc_en = 1'b0;
        @(negedge clk) start = 1'b0;
        waited = 0;
        while (rf_raddr != 5'd10 && waited < 500) begin @(negedge clk); waited++; end
        check("reach_reg10", rf_raddr, 5'd10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", dump_valid, 1'b0);
        check("arst_cpu_run", cpu_run, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rf_raddr", rf_raddr, 5'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {busy, done, dump_valid}, 3'd0);
        fill_state();
        do_run(32'd4, 1'b0, 32'd0, 2);

        for (int r = 0; r < 3; r++) begin
            fill_state();
            pc0 = cpu_pc;
            do_run(32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   pc0 + 32'(4 * $urandom_range(0, 15)), 2);
        end

        // Second instance: zero limit, 2-word window at byte 0x20.
        mem[8] = 32'hDEAD_BEEF;
        mem[9] = 32'h0000_0007;
        mem2_q.delete(); addr2_q.delete(); run_cnt2 = 0; beat_cnt2 = 0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        check("lim0_no_run", cpu_run2, 1'b0);
        check("lim0_busy", busy2, 1'b1);
        @(negedge clk);
        check("lim0_pc_beat", {dump_valid2, dump_kind2}, {1'b1, KIND_PC});
        waited = 0;
        while (!done2 && waited < 500) begin @(negedge clk); waited++; end
        check("w2_done", done2, 1'b1);
        check("w2_run_cycles", run_cnt2, 0);
        check("w2_reason", halt_reason2, 2'b01);
        check("w2_beats", beat_cnt2, 35);
        check("w2_mem_beats", mem2_q.size(), 2);
        if (mem2_q.size() == 2) begin
            check("w2_mem0", mem2_q[0], {8'd0, 32'hDEAD_BEEF});
            check("w2_mem1", mem2_q[1], {8'd1, 32'h0000_0007});
        end
        check("w2_addr_cnt", addr2_q.size(), 2);
        if (addr2_q.size() == 2) begin
            check("w2_addr0", addr2_q[0], 32'h20);
            check("w2_addr1", addr2_q[1], 32'h24);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
